// File: rtl/fp_wb_pkg.sv
// fp_wb_pkg: shared types for the FP result return path.
// The optional bypass in fp_result_collector is controlled by the macro FP_RESULT_BYPASS_EN.
package fp_wb_pkg;

  localparam int FLAGS_W = 5;

  // IEEE exception flags, MSB first: invalid, div-by-zero, overflow, underflow, inexact
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // Destination tag attached at issue and carried through the FPU untouched
  typedef struct packed {
    logic       int_dst;
    logic [4:0] rd;
  } fp_tag_t;

  // One buffered FPU completion
  typedef struct packed {
    fp_tag_t     tag;
    logic [31:0] result;
    fflags_t     status;
  } fp_result_entry_t;

  // Sticky flag update: a clear wipes the old value, a retiring result ORs its status in.
  function automatic logic [FLAGS_W-1:0] fflags_next(
    input logic [FLAGS_W-1:0] cur,
    input logic               clr,
    input logic               retire,
    input logic [FLAGS_W-1:0] status
  );
    logic [FLAGS_W-1:0] base;
    base = clr ? '0 : cur;
    return retire ? (base | status) : base;
  endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: generic DEPTH-entry synchronous FIFO of fp_result_entry_t.
// Pointers carry one extra wrap bit; full/empty come from comparing it.
// Head is a direct read of registered storage so the consumer sees it with no extra latency.
module fp_result_fifo
  import fp_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  fp_result_entry_t       entry_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fp_result_entry_t       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  fp_result_entry_t mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push coinciding with a flush is dropped; pops on an empty queue are ignored
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  // Next-state pointer arithmetic; flush returns both pointers to zero
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only observed through valid pointers so it needs no reset
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/fp_result_collector.sv
// fp_result_collector: buffers FPU completions in order and retires them to the FP
// register file or the stallable integer writeback port, accumulating sticky fflags.
// Optional macro FP_RESULT_BYPASS_EN: an FP-destination result arriving at an empty
// queue is written in its accept cycle instead of being stored.
module fp_result_collector
  import fp_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fpu_out_valid_i,
  output logic                   fpu_out_ready_o,
  input  logic [31:0]            fpu_result_i,
  input  logic [4:0]             fpu_status_i,
  input  logic [5:0]             fpu_tag_i,
  input  logic                   flush_i,
  output logic                   fp_we_o,
  output logic [4:0]             fp_waddr_o,
  output logic [31:0]            fp_wdata_o,
  output logic                   int_we_o,
  output logic [4:0]             int_waddr_o,
  output logic [31:0]            int_wdata_o,
  input  logic                   int_ready_i,
  output logic [4:0]             fflags_o,
  input  logic                   fflags_clr_i,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] count_o
);

  fp_result_entry_t     in_entry;
  fp_result_entry_t     head;
  logic                 full;
  logic                 empty;
  logic                 head_fp;
  logic                 head_int;
  logic                 pop;
  logic                 push_req;
  logic                 ret_vld;
  logic [FLAGS_W-1:0]   ret_status;
  logic [FLAGS_W-1:0]   fflags_q, fflags_d;

  assign in_entry = {fpu_tag_i, fpu_result_i, fpu_status_i};

  // Ready depends only on registered occupancy, never on the retire side
  assign fpu_out_ready_o = !full;
  assign busy_o          = !empty;

  // Head decode: the destination bit of the oldest entry selects the retire port
  assign head_fp  = !empty && !head.tag.int_dst;
  assign head_int = !empty &&  head.tag.int_dst;

  // FP heads retire unconditionally; integer heads wait for the writeback handshake
  assign pop = head_fp || (head_int && int_ready_i);

  assign int_we_o    = head_int;
  assign int_waddr_o = head_int ? head.tag.rd : '0;
  assign int_wdata_o = head_int ? head.result : '0;

`ifdef FP_RESULT_BYPASS_EN
  logic byp;

  // Empty queue plus FP destination: write straight through, skip storage
  assign byp        = empty && fpu_out_valid_i && !fpu_tag_i[5] && !flush_i;
  assign push_req   = fpu_out_valid_i && !byp;
  assign fp_we_o    = head_fp || byp;
  assign fp_waddr_o = byp ? fpu_tag_i[4:0] : (head_fp ? head.tag.rd : '0);
  assign fp_wdata_o = byp ? fpu_result_i   : (head_fp ? head.result : '0);
  assign ret_vld    = pop || byp;
  assign ret_status = byp ? fpu_status_i : head.status;
`else
  assign push_req   = fpu_out_valid_i;
  assign fp_we_o    = head_fp;
  assign fp_waddr_o = head_fp ? head.tag.rd : '0;
  assign fp_wdata_o = head_fp ? head.result : '0;
  assign ret_vld    = pop;
  assign ret_status = head.status;
`endif

  fp_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_req),
    .entry_i (in_entry),
    .pop_i   (pop),
    .flush_i (flush_i),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  // Sticky flag next state; a clear in a retire cycle keeps only the retiring status
  always_comb begin
    fflags_d = fflags_next(fflags_q, fflags_clr_i, ret_vld, ret_status);
  end

  // Sticky flag register; flush leaves it alone
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fflags_q <= '0;
    else       fflags_q <= fflags_d;
  end

  assign fflags_o = fflags_q;

endmodule
